// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared definitions for the 8x8 sequential shift-and-add multiplier:
// operand/product widths, iteration count and the controller state encoding.
package mult8_seq_ctrl_pkg;

  localparam int OP_W       = 8;
  localparam int PROD_W     = 2 * OP_W;
  localparam int MULT_STEPS = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value seen on the final shift-add step.
  function automatic logic [CNT_W-1:0] last_step();
    return CNT_W'(MULT_STEPS - 1);
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Start/busy/done handshake plus operand and product buses of the multiplier.
// The requester drives the master side, the controller sits on the slave side.
interface mult8_seq_ctrl_if;
  import mult8_seq_ctrl_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mult8_seq_ctrl_add_eight.sv
// add_eight: plain 8-bit ripple-carry adder shared by the sequential datapaths.
module add_eight (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // Carry ripples bit by bit from cin to cout.
  always_comb begin
    logic w_c;
    s   = '0;
    w_c = cin;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ w_c;
      w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencing controller for an 8x8 unsigned shift-and-add multiplier.
// One add_eight instance is reused over eight cycles; the product is {H,Q}.
//
// state | meaning
// IDLE  | waiting for start; product shows last result (0 after reset)
// RUN   | one shift-add step per cycle, eight steps total
// DONE  | one-cycle done pulse; start here begins the next multiply at once
module mult8_seq_ctrl
  import mult8_seq_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  mult8_seq_ctrl_if.slave  mul_if
);

  state_t              r_state;
  logic [OP_W-1:0]     r_m;
  logic [OP_W-1:0]     r_h;
  logic [OP_W-1:0]     r_q;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_W-1:0]   r_product;

  state_t              w_state_nxt;
  logic                w_accept;
  logic [OP_W-1:0]     w_addend;
  logic [OP_W-1:0]     w_sum;
  logic                w_cout;
  logic [OP_W-1:0]     w_h_nxt;
  logic [OP_W-1:0]     w_q_nxt;

  // Partial product: add M only when the current multiplier LSB is set.
  assign w_addend = r_q[0] ? r_m : '0;

  add_eight u_add (
    .a    (r_h),
    .b    (w_addend),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Shifting {cout, sum, Q} right by one absorbs the carry into H[7].
  assign w_h_nxt = {w_cout, w_sum[OP_W-1:1]};
  assign w_q_nxt = {w_sum[0], r_q[OP_W-1:1]};

  // Next-state decode; start is only accepted from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mul_if.start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == last_step()) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (mul_if.start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; the product register is cleared on accept
  // and loaded with the final {H,Q} on the last step so it is valid in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_h       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_m       <= mul_if.a;
        r_q       <= mul_if.b;
        r_h       <= '0;
        r_cnt     <= '0;
        r_product <= '0;
      end else if (r_state == ST_RUN) begin
        r_h   <= w_h_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == last_step()) begin
          r_product <= {w_h_nxt, w_q_nxt};
        end
      end
    end
  end

  assign mul_if.busy    = (r_state == ST_RUN);
  assign mul_if.done    = (r_state == ST_DONE);
  assign mul_if.product = r_product;

endmodule
